// File: rtl/neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_if
// Description : Handshake/data bundle for the neuron_mac block.
//               master : the evaluation controller (drives start, bias, the
//                        x/w stream and out_ready).
//               slave  : the neuron_mac block itself.
//   start/bias            evaluation request and bias value
//   in_valid/in_ready     x/w pair stream handshake, data on in_x/in_w
//   out_valid/out_ready   result handshake, data on out_sum/out_ovf
//   busy                  block is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface neuron_mac_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 start;
    logic [BIT_WIDTH-1:0] bias;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_x;
    logic [BIT_WIDTH-1:0] in_w;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_sum;
    logic                 out_ovf;
    logic                 busy;

    modport master (
        output start, bias, in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  start, bias, in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Streaming fixed-point multiply-accumulate neuron. Loads a
//               bias, accumulates NUM_INPUTS signed x*w products at full
//               precision, rounds half-up back to FRACTION_WIDTH fractional
//               bits, saturates to BIT_WIDTH and offers the result on a
//               valid/ready output.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - neuron_mac_if slave (start/bias, x/w stream,
//                        result stream, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac #(
    parameter int FRACTION_WIDTH = 15,
    parameter int BIT_WIDTH      = 32,
    parameter int NUM_INPUTS     = 16
) (
    input  wire          clk,
    input  wire          rst_n,
    neuron_mac_if.slave  bus
);
    localparam int CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    // Wide enough that NUM_INPUTS full-scale products plus the bias cannot wrap.
    localparam int ACC_W  = 2*BIT_WIDTH + $clog2(NUM_INPUTS) + 1;
    // One extra bit so adding the rounding constant cannot wrap either.
    localparam int RND_W  = ACC_W + 1;
    localparam int PROD_W = 2*BIT_WIDTH;

    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(NUM_INPUTS-1);
    localparam logic signed [RND_W-1:0] HALF_LSB = RND_W'(1) << (FRACTION_WIDTH-1);
    localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'({1'b0, {(BIT_WIDTH-1){1'b1}}});
    localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'($signed({1'b1, {(BIT_WIDTH-1){1'b0}}}));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [RND_W-1:0]  rounded_sum;
    logic signed [RND_W-1:0]  rounded;
    logic                     beat;

    // Operands are sign-extended to the product width so the multiply is
    // exact without relying on context-width rules.
    assign x_ext       = PROD_W'($signed(bus.in_x));
    assign w_ext       = PROD_W'($signed(bus.in_w));
    assign product     = x_ext * w_ext;
    assign bias_ext    = ACC_W'($signed(bus.bias));
    assign rounded_sum = RND_W'(acc) + HALF_LSB;
    assign rounded     = rounded_sum >>> FRACTION_WIDTH;
    assign beat        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc          <= bias_ext <<< FRACTION_WIDTH;
                        count        <= '0;
                        bus.in_ready <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= acc + ACC_W'(product);
                        count <= count + 1'b1;
                        if (count == LAST_CNT) begin
                            bus.in_ready <= 1'b0;
                            state        <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    if (rounded > SAT_MAX) begin
                        bus.out_sum <= SAT_MAX[BIT_WIDTH-1:0];
                        bus.out_ovf <= 1'b1;
                    end else if (rounded < SAT_MIN) begin
                        bus.out_sum <= SAT_MIN[BIT_WIDTH-1:0];
                        bus.out_ovf <= 1'b1;
                    end else begin
                        bus.out_sum <= rounded[BIT_WIDTH-1:0];
                        bus.out_ovf <= 1'b0;
                    end
                    bus.out_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    // start in the accept cycle is deliberately not looked at;
                    // the block only reacts to start once back in IDLE.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
